// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard controller: forwarding selects, FSM
// states and the shadow entry tracked for each of EX/MEM/WB.
package hazard_ctrl_pkg;

  // Shadow rd field is sized for the widest register index supported.
  localparam int REG_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic                 is_load;
  } hz_entry_t;

  // Writes to x0 are architecturally dropped, so they never become producers.
  function automatic hz_entry_t make_entry(input logic                 wr,
                                           input logic [REG_W_MAX-1:0] rd,
                                           input logic                 is_load);
    hz_entry_t e;
    e.valid   = wr && (rd != '0);
    e.rd      = rd;
    e.is_load = is_load;
    return e;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Per-operand producer search: youngest in-flight writer wins; also flags a
// load sitting in EX that this operand depends on.
module hazard_ctrl_fwd_match
  import hazard_ctrl_pkg::*;
(
  input  hz_entry_t            i_ex,
  input  hz_entry_t            i_mem,
  input  hz_entry_t            i_wb,
  input  logic [REG_W_MAX-1:0] i_rs,
  input  logic                 i_use,
  output fwd_sel_t             o_sel,
  output logic                 o_load_use
);

  logic w_active;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_active   = i_use && (i_rs != '0);
  assign w_ex_hit   = w_active && i_ex.valid  && (i_ex.rd  == i_rs);
  assign w_mem_hit  = w_active && i_mem.valid && (i_mem.rd == i_rs);
  assign w_wb_hit   = w_active && i_wb.valid  && (i_wb.rd  == i_rs);
  assign o_load_use = w_ex_hit && i_ex.is_load;

  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit)       o_sel = FWD_EX;
    else if (w_mem_hit) o_sel = FWD_MEM;
    else if (w_wb_hit)  o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard/flush controller: forwarding selects, load-use stall,
// redirect flush window and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_W        = 5,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_wr_rd_i,
  input  logic             id_is_load_i,
  input  logic             ex_redirect_i,
  output logic             issue_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  hz_entry_t        r_ex, r_mem, r_wb;
  hz_state_t        r_state;
  logic [FC_W-1:0]  r_fcnt;
  logic [CNT_W-1:0] r_stall_cnt;

  hz_entry_t w_id;
  fwd_sel_t  w_sel_a, w_sel_b;
  logic      w_lu_a, w_lu_b, w_load_use, w_flush, w_stall, w_issue;

  hazard_ctrl_fwd_match u_fwd_a (
    .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb),
    .i_rs(REG_W_MAX'(id_rs1_i)), .i_use(id_use_rs1_i),
    .o_sel(w_sel_a), .o_load_use(w_lu_a)
  );

  hazard_ctrl_fwd_match u_fwd_b (
    .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb),
    .i_rs(REG_W_MAX'(id_rs2_i)), .i_use(id_use_rs2_i),
    .o_sel(w_sel_b), .o_load_use(w_lu_b)
  );

  // ID advances only when it holds a real instruction and is neither held
  // (stall) nor killed (flush); flush takes precedence over stall.
  assign w_load_use = w_lu_a || w_lu_b;
  assign w_flush    = ex_redirect_i || (r_state == HZ_FLUSH);
  assign w_stall    = w_load_use && !w_flush;
  assign w_issue    = id_valid_i && !w_stall && !w_flush;
  assign w_id       = make_entry(id_wr_rd_i, REG_W_MAX'(id_rd_i), id_is_load_i);

  assign issue_o     = w_issue;
  assign stall_o     = w_stall;
  assign flush_o     = w_flush;
  assign fwd_a_o     = w_load_use ? FWD_RF : w_sel_a;
  assign fwd_b_o     = w_load_use ? FWD_RF : w_sel_b;
  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;

  // r_fcnt holds the FLUSH-state cycles still to run, including the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_state     <= HZ_RUN;
      r_fcnt      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_issue ? w_id : '0;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (ex_redirect_i) begin
        r_fcnt  <= FC_LOAD;
        r_state <= (FC_LOAD == '0) ? HZ_RUN : HZ_FLUSH;
      end else begin
        unique case (r_state)
          HZ_RUN:   r_state <= w_stall ? HZ_STALL : HZ_RUN;
          HZ_STALL: r_state <= HZ_RUN;
          HZ_FLUSH: begin
            if (r_fcnt <= FC_W'(1)) begin
              r_fcnt  <= '0;
              r_state <= HZ_RUN;
            end else begin
              r_fcnt <= r_fcnt - FC_W'(1);
            end
          end
          default:  r_state <= HZ_RUN;
        endcase
      end
    end
  end

endmodule
